a_operand_arbiter: RTL and testbench

//  Round-robin arbiter that shares the operand port set (d1/d2/d3) of the

---
 rtl/a_operand_arbiter.sv | 113 +++++++++++
 tb/tb_a_operand_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/a_operand_arbiter.sv
// Round-robin operand arbiter in front of datapath "a": latches the winner's
// d1/d2/d3 operands and holds them stable for g_delay cycles before re-arbitrating.
module a_operand_arbiter #(
   parameter int g_w1    = 8,
   parameter int g_w2    = 32,
   parameter int g_w3    = 16,
   parameter int g_delay = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic [2:0]              req,
   input  logic [3*g_w1-1:0]       req_d1,
   input  logic [3*(g_w2+2)-1:0]   req_d2,
   input  logic [3*g_w3*2-1:0]     req_d3,
   output logic [2:0]              grant,
   output logic [g_w1-1:0]         d1,
   output logic [g_w2+1:0]         d2,
   output logic [g_w3*2-1:0]       d3,
   output logic                    d_valid,
   output logic                    busy
);

   localparam int CW = $clog2(g_delay + 1);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t              state, state_nxt;
   logic [CW-1:0]       cnt, cnt_nxt;
   logic [1:0]          ptr, ptr_nxt;
   logic [1:0]          win;
   logic                arb_en;
   logic [2:0]          grant_nxt;
   logic [g_w1-1:0]     d1_nxt;
   logic [g_w2+1:0]     d2_nxt;
   logic [g_w3*2-1:0]   d3_nxt;
   logic                valid_nxt, busy_nxt;

   // Search ptr+1, ptr+2, ptr+3 (mod 3); scanning backwards lets the nearest hit win.
   function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] p);
      logic [1:0] w;
      int         t;
      w = 2'd0;
      for (int k = 3; k >= 1; k--) begin
         t = (int'(p) + k) % 3;
         if (r[t]) w = 2'(t);
      end
      return w;
   endfunction

   assign win    = pick(req, ptr);
   assign arb_en = (state == IDLE) || (cnt == '0);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ptr_nxt   = ptr;
      grant_nxt = 3'b000;
      d1_nxt    = d1;
      d2_nxt    = d2;
      d3_nxt    = d3;
      valid_nxt = d_valid;
      busy_nxt  = busy;
      if (flush) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         valid_nxt = 1'b0;
         busy_nxt  = 1'b0;
      end else if (arb_en && (req != 3'b000)) begin
         state_nxt = HOLD;
         cnt_nxt   = CW'(g_delay - 1);
         ptr_nxt   = win;
         grant_nxt = 3'b001 << win;
         d1_nxt    = req_d1[win*g_w1 +: g_w1];
         d2_nxt    = req_d2[win*(g_w2+2) +: (g_w2+2)];
         d3_nxt    = req_d3[win*(g_w3*2) +: (g_w3*2)];
         valid_nxt = 1'b1;
         busy_nxt  = 1'b1;
      end else if ((state == HOLD) && (cnt != '0)) begin
         cnt_nxt = cnt - CW'(1);
      end else begin
         // Hold window expired with nobody waiting; operands keep their last value.
         state_nxt = IDLE;
         valid_nxt = 1'b0;
         busy_nxt  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         ptr     <= 2'd2;
         grant   <= 3'b000;
         d1      <= '0;
         d2      <= '0;
         d3      <= '0;
         d_valid <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         ptr     <= ptr_nxt;
         grant   <= grant_nxt;
         d1      <= d1_nxt;
         d2      <= d2_nxt;
         d3      <= d3_nxt;
         d_valid <= valid_nxt;
         busy    <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_a_operand_arbiter.sv
// Bench for a_operand_arbiter: a g_delay=5 and a g_delay=1 instance share one
// stimulus stream and are compared every cycle against a window-count model.
module tb_a_operand_arbiter;

   localparam int W1 = 8, W2 = 32, W3 = 16;

   logic              clk = 1'b0;
   logic              rst_n, flush;
   logic [2:0]        req;
   logic [3*W1-1:0]   req_d1;
   logic [3*(W2+2)-1:0] req_d2;
   logic [3*W3*2-1:0] req_d3;

   logic [2:0]        grant [2];
   logic [W1-1:0]     d1 [2];
   logic [W2+1:0]     d2 [2];
   logic [W3*2-1:0]   d3 [2];
   logic              d_valid [2];
   logic              busy [2];

   int npass = 0;
   int ntotal = 0;

   // reference model state, one slot per instance
   int                dly [2] = '{5, 1};
   int                m_rem [2];
   int                m_ptr [2];
   logic [2:0]        m_grant [2];
   logic [W1-1:0]     m_d1 [2];
   logic [W2+1:0]     m_d2 [2];
   logic [W3*2-1:0]   m_d3 [2];

   always #5 clk = ~clk;

   a_operand_arbiter #(.g_w1(W1), .g_w2(W2), .g_w3(W3), .g_delay(5)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .req(req),
      .req_d1(req_d1), .req_d2(req_d2), .req_d3(req_d3),
      .grant(grant[0]), .d1(d1[0]), .d2(d2[0]), .d3(d3[0]),
      .d_valid(d_valid[0]), .busy(busy[0]));

   a_operand_arbiter #(.g_w1(W1), .g_w2(W2), .g_w3(W3), .g_delay(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .req(req),
      .req_d1(req_d1), .req_d2(req_d2), .req_d3(req_d3),
      .grant(grant[1]), .d1(d1[1]), .d2(d2[1]), .d3(d3[1]),
      .d_valid(d_valid[1]), .busy(busy[1]));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   // One edge of behaviour: a grant opens a window of dly cycles; a new grant
   // is allowed when idle or in the final cycle of the window.
   task automatic model_step(input int i);
      int w;
      if (!rst_n) begin
         m_rem[i] = 0; m_ptr[i] = 2; m_grant[i] = 3'b000;
         m_d1[i] = '0; m_d2[i] = '0; m_d3[i] = '0;
      end else if (flush) begin
         m_rem[i] = 0; m_grant[i] = 3'b000;
      end else if (m_rem[i] <= 1 && req != 3'b000) begin
         w = -1;
         for (int k = 1; k <= 3; k++)
            if (w < 0 && req[(m_ptr[i] + k) % 3]) w = (m_ptr[i] + k) % 3;
         m_grant[i] = 3'b000;
         m_grant[i][w] = 1'b1;
         m_d1[i] = req_d1[w*W1 +: W1];
         m_d2[i] = req_d2[w*(W2+2) +: (W2+2)];
         m_d3[i] = req_d3[w*W3*2 +: W3*2];
         m_rem[i] = dly[i];
         m_ptr[i] = w;
      end else begin
         m_grant[i] = 3'b000;
         if (m_rem[i] > 0) m_rem[i]--;
      end
   endtask

   task automatic compare(input int i);
      string s;
      s = (i == 0) ? "d5" : "d1";
      chk({s, ".grant"},   64'(grant[i]),   64'(m_grant[i]));
      chk({s, ".d_valid"}, 64'(d_valid[i]), 64'(m_rem[i] > 0));
      chk({s, ".busy"},    64'(busy[i]),    64'(m_rem[i] > 0));
      chk({s, ".d1"},      64'(d1[i]),      64'(m_d1[i]));
      chk({s, ".d2"},      64'(d2[i]),      64'(m_d2[i]));
      chk({s, ".d3"},      64'(d3[i]),      64'(m_d3[i]));
   endtask

   // Drive inputs for n cycles with fresh random operands each cycle.
   task automatic run(input logic r_n, input logic fl, input logic [2:0] r, input int n);
      for (int c = 0; c < n; c++) begin
         rst_n = r_n; flush = fl; req = r;
         req_d1 = {$urandom, $urandom};
         req_d2 = {$urandom, $urandom, $urandom, $urandom};
         req_d3 = {$urandom, $urandom, $urandom};
         @(posedge clk);
         model_step(0);
         model_step(1);
         #1;
         compare(0);
         compare(1);
      end
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; req = 3'b000;
      req_d1 = '0; req_d2 = '0; req_d3 = '0;
      #2;
      // reset state
      run(1'b0, 1'b0, 3'b000, 2);
      run(1'b1, 1'b0, 3'b000, 2);
      // single request, full hold window then idle
      run(1'b1, 1'b0, 3'b001, 1);
      run(1'b1, 1'b0, 3'b000, 7);
      // all requesting: back-to-back rotation without bubbles
      run(1'b1, 1'b0, 3'b111, 20);
      run(1'b1, 1'b0, 3'b000, 6);
      // rotation after grant to 2, then after grant to 0
      run(1'b1, 1'b0, 3'b100, 1);
      run(1'b1, 1'b0, 3'b000, 6);
      run(1'b1, 1'b0, 3'b101, 1);
      run(1'b1, 1'b0, 3'b000, 6);
      run(1'b1, 1'b0, 3'b101, 1);
      run(1'b1, 1'b0, 3'b000, 6);
      // alternating pair (exercises the g_delay=1 instance every cycle)
      run(1'b1, 1'b0, 3'b011, 10);
      run(1'b1, 1'b0, 3'b000, 6);
      // flush in the third hold cycle, then re-request
      run(1'b1, 1'b0, 3'b001, 1);
      run(1'b1, 1'b0, 3'b000, 2);
      run(1'b1, 1'b1, 3'b000, 1);
      run(1'b1, 1'b0, 3'b001, 1);
      run(1'b1, 1'b0, 3'b000, 6);
      // flush and reset together: reset wins
      run(1'b1, 1'b0, 3'b010, 1);
      run(1'b0, 1'b1, 3'b010, 1);
      run(1'b1, 1'b0, 3'b000, 2);
      // reset mid-hold, then 3'b110 must go to requester 1
      run(1'b1, 1'b0, 3'b111, 3);
      run(1'b0, 1'b0, 3'b111, 1);
      run(1'b1, 1'b0, 3'b110, 1);
      run(1'b1, 1'b0, 3'b000, 6);
      // random traffic with occasional flush/reset
      for (int n = 0; n < 400; n++)
         run(($urandom_range(0, 49) != 0), ($urandom_range(0, 29) == 0),
             ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom), $urandom_range(1, 3));
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
